// File: rtl/pp_pkg.sv
// Shared definitions for the program sequencer.
// ALU operation codes, state encoding and the instruction word.
package pp_pkg;

    localparam logic [2:0] ALU_LD   = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_ST   = 3'b011;
    localparam logic [2:0] ALU_NOT  = 3'b100;
    localparam logic [2:0] ALU_AND  = 3'b101;
    localparam logic [2:0] ALU_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_EXEC      = 3'd2,
        S_WAIT_STEP = 3'd3,
        S_HALT      = 3'd4
    } state_t;

    typedef struct packed {
        logic [3:0] reg_addr;
        logic [2:0] alu_code;
        logic       reg_ce;
        logic       cy_ce;
        logic       a_ce;
        logic       reset_cy;
    } instr_t;

    // Instruction counter increment that sticks at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pp_seq_if.sv
// Program-store and datapath bus of the sequencer.
// master = sequencer, slave = program store plus datapath.
interface pp_seq_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] Addr;
    logic [3:0]        RomRegAddr;
    logic [2:0]        RomALUCode;
    logic              RomReg_CE;
    logic              RomCY_CE;
    logic              RomA_CE;
    logic              RomResetCY;
    logic [3:0]        RegAddr;
    logic [2:0]        ALUCode;
    logic              Reg_CE;
    logic              CY_CE;
    logic              A_CE;
    logic              ResetCY;

    modport master (
        output Addr,
        input  RomRegAddr, RomALUCode,
        input  RomReg_CE, RomCY_CE, RomA_CE, RomResetCY,
        output RegAddr, ALUCode,
        output Reg_CE, CY_CE, A_CE, ResetCY
    );

    modport slave (
        input  Addr,
        output RomRegAddr, RomALUCode,
        output RomReg_CE, RomCY_CE, RomA_CE, RomResetCY,
        input  RegAddr, ALUCode,
        input  Reg_CE, CY_CE, A_CE, ResetCY
    );

endinterface

// File: rtl/pp_seq.sv
// Program sequencer: fetches from a combinational store and
// drives datapath enables for one cycle per instruction.
module pp_seq
    import pp_pkg::*;
#(
    parameter int         ADDR_W    = 5,
    parameter logic [2:0] HALT_CODE = ALU_HALT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic        Abort,
    input  logic        Step_Mode,
    input  logic        Step,
    pp_seq_if.master    bus,
    output logic        Busy,
    output logic        Done,
    output logic [7:0]  InstrCount
);

    localparam logic [ADDR_W-1:0] PC_LAST = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    instr_t            ir_q, ir_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    instr_t            rom_instr;
    logic              in_exec;

    assign rom_instr = '{
        reg_addr: bus.RomRegAddr,
        alu_code: bus.RomALUCode,
        reg_ce:   bus.RomReg_CE,
        cy_ce:    bus.RomCY_CE,
        a_ce:     bus.RomA_CE,
        reset_cy: bus.RomResetCY
    };

    // Next-state, PC, instruction register and counter update.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        if (Abort) begin
            state_d = S_IDLE;
            pc_d    = '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_HALT: begin
                    if (Start) begin
                        state_d = S_FETCH;
                        pc_d    = '0;
                        cnt_d   = '0;
                    end
                end
                S_FETCH: begin
                    if (bus.RomALUCode == HALT_CODE) begin
                        state_d = S_HALT;
                    end else begin
                        ir_d    = rom_instr;
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    cnt_d = sat_inc8(cnt_q);
                    if (pc_q == PC_LAST) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = Step_Mode ? S_WAIT_STEP : S_FETCH;
                    end
                end
                S_WAIT_STEP: begin
                    if (Step || !Step_Mode) begin
                        state_d = S_FETCH;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        busy_d = (state_d == S_FETCH) ||
                 (state_d == S_EXEC) ||
                 (state_d == S_WAIT_STEP);
        done_d = (state_d == S_HALT);
    end

    // State and status registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Enables come straight from flops, so reset kills them at once;
    // Abort is the only input allowed to gate them combinationally.
    assign in_exec = (state_q == S_EXEC);

    assign bus.Addr    = pc_q;
    assign bus.RegAddr = in_exec ? ir_q.reg_addr : 4'b0000;
    assign bus.ALUCode = in_exec ? ir_q.alu_code : 3'b000;
    assign bus.Reg_CE  = in_exec & ir_q.reg_ce   & ~Abort;
    assign bus.CY_CE   = in_exec & ir_q.cy_ce    & ~Abort;
    assign bus.A_CE    = in_exec & ir_q.a_ce     & ~Abort;
    assign bus.ResetCY = in_exec & ir_q.reset_cy & ~Abort;

    assign Busy       = busy_q;
    assign Done       = done_q;
    assign InstrCount = cnt_q;

endmodule

// File: tb/tb_pp_seq.sv
// Bench for pp_seq: run-level reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_pp_seq;

    typedef struct packed {
        logic [3:0] ra;
        logic [2:0] alu;
        logic       rce;
        logic       cce;
        logic       ace;
        logic       rcy;
    } rom_t;

    localparam int PH_IDLE  = 0;
    localparam int PH_FETCH = 1;
    localparam int PH_EXEC  = 2;
    localparam int PH_WAIT  = 3;
    localparam int PH_HALT  = 4;

    logic clk = 1'b0;
    logic rst_n, Start, Abort, Step_Mode, Step;
    logic Busy, Done;
    logic [7:0] InstrCount;

    rom_t rom [32];

    int vectors = 0;
    int miscompares = 0;
    int acnt = 0;
    int wrapped = 0;
    logic prev_busy = 1'b0;
    logic [4:0] prev_addr = '0;

    int   m_ph;
    int   m_pc;
    int   m_cnt;
    rom_t m_cur;

    pp_seq_if #(.ADDR_W(5)) bus ();

    pp_seq #(.ADDR_W(5), .HALT_CODE(3'b111)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Start      (Start),
        .Abort      (Abort),
        .Step_Mode  (Step_Mode),
        .Step       (Step),
        .bus        (bus),
        .Busy       (Busy),
        .Done       (Done),
        .InstrCount (InstrCount)
    );

    always #5 clk = ~clk;

    assign bus.RomRegAddr = rom[bus.Addr].ra;
    assign bus.RomALUCode = rom[bus.Addr].alu;
    assign bus.RomReg_CE  = rom[bus.Addr].rce;
    assign bus.RomCY_CE   = rom[bus.Addr].cce;
    assign bus.RomA_CE    = rom[bus.Addr].ace;
    assign bus.RomResetCY = rom[bus.Addr].rcy;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Program A: 13 instructions then HALT at address 13.
    task automatic load_prog_a();
        for (int k = 0; k < 32; k++) begin
            rom[k].ra  = 4'(1 << (k % 4));
            rom[k].alu = 3'(k % 6);
            rom[k].rce = (k % 3) != 1;
            rom[k].cce = (k % 2) == 0;
            rom[k].ace = 1'b1;
            rom[k].rcy = (k % 4) == 3;
        end
        rom[13].alu = 3'b111;
    endtask

    // Program B: 32 instructions, no HALT code anywhere.
    task automatic load_prog_b();
        for (int k = 0; k < 32; k++) begin
            rom[k].ra  = 4'(1 << (k % 4));
            rom[k].alu = 3'(k % 6);
            rom[k].rce = 1'b1;
            rom[k].cce = (k % 2) == 1;
            rom[k].ace = 1'b1;
            rom[k].rcy = 1'b0;
        end
    endtask

    // Reference model: run-level bookkeeping of where the program is.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph  <= PH_IDLE;
            m_pc  <= 0;
            m_cnt <= 0;
            m_cur <= '0;
        end else if (Abort) begin
            m_ph <= PH_IDLE;
            m_pc <= 0;
        end else begin
            case (m_ph)
                PH_IDLE, PH_HALT:
                    if (Start) begin
                        m_ph  <= PH_FETCH;
                        m_pc  <= 0;
                        m_cnt <= 0;
                    end
                PH_FETCH:
                    if (rom[m_pc].alu == 3'b111) begin
                        m_ph <= PH_HALT;
                    end else begin
                        m_cur <= rom[m_pc];
                        m_ph  <= PH_EXEC;
                    end
                PH_EXEC: begin
                    m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
                    if (m_pc == 31) begin
                        m_ph <= PH_HALT;
                    end else begin
                        m_pc <= m_pc + 1;
                        m_ph <= Step_Mode ? PH_WAIT : PH_FETCH;
                    end
                end
                PH_WAIT:
                    if (Step || !Step_Mode) m_ph <= PH_FETCH;
                default: m_ph <= PH_IDLE;
            endcase
        end
    end

    // Compare process: every cycle, mid-period.
    always @(negedge clk) begin
        automatic bit ex = (m_ph == PH_EXEC);
        automatic bit go = ex && !Abort;
        chk("Addr", int'(bus.Addr), m_pc);
        chk("Busy", int'(Busy), int'(m_ph == PH_FETCH || ex || m_ph == PH_WAIT));
        chk("Done", int'(Done), int'(m_ph == PH_HALT));
        chk("InstrCount", int'(InstrCount), m_cnt);
        chk("RegAddr", int'(bus.RegAddr), ex ? int'(m_cur.ra) : 0);
        chk("ALUCode", int'(bus.ALUCode), ex ? int'(m_cur.alu) : 0);
        chk("Reg_CE", int'(bus.Reg_CE), int'(go && m_cur.rce));
        chk("CY_CE", int'(bus.CY_CE), int'(go && m_cur.cce));
        chk("A_CE", int'(bus.A_CE), int'(go && m_cur.ace));
        chk("ResetCY", int'(bus.ResetCY), int'(go && m_cur.rcy));
    end

    // Activity monitor: A_CE pulses and PC wrap detection.
    always @(negedge clk) begin
        if (bus.A_CE) acnt++;
        if (prev_busy && Busy && prev_addr == 5'd31 && bus.Addr == 5'd0)
            wrapped++;
        prev_busy <= Busy;
        prev_addr <= bus.Addr;
    end

    initial begin
        int base;
        rst_n = 1'b0;
        Start = 1'b0;
        Abort = 1'b0;
        Step_Mode = 1'b0;
        Step = 1'b0;
        load_prog_a();
        #1;
        chk("rst_busy", int'(Busy), 0);
        chk("rst_done", int'(Done), 0);
        chk("rst_cnt", int'(InstrCount), 0);
        chk("rst_addr", int'(bus.Addr), 0);
        chk("rst_ace", int'(bus.A_CE), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Free-running program: instruction k executes at cycle 2k+2.
        Start = 1'b1;
        for (int c = 1; c <= 28; c++) begin
            tick();
            if (c == 1) Start = 1'b0;
            if (c == 2) begin
                chk("c2_addr", int'(bus.Addr), 0);
                chk("c2_ace", int'(bus.A_CE), 1);
            end
            if (c == 4) begin
                chk("c4_addr", int'(bus.Addr), 1);
                chk("c4_alu", int'(bus.ALUCode), 1);
            end
            if (c == 24) begin
                chk("c24_addr", int'(bus.Addr), 11);
                chk("c24_alu", int'(bus.ALUCode), 5);
            end
            if (c == 25) chk("c25_ace", int'(bus.A_CE), 0);
            if (c == 27) begin
                chk("c27_addr", int'(bus.Addr), 13);
                chk("c27_done", int'(Done), 0);
                chk("c27_busy", int'(Busy), 1);
            end
            if (c == 28) begin
                chk("c28_done", int'(Done), 1);
                chk("c28_busy", int'(Busy), 0);
                chk("c28_cnt", int'(InstrCount), 13);
            end
        end

        // Single-step mode.
        Step_Mode = 1'b1;
        base = acnt;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        tick();
        for (int p = 0; p < 3; p++) begin
            tick();
            tick();
            Step = 1'b1;
            tick();
            Step = 1'b0;
            tick();
            tick();
        end
        chk("step_pulses", acnt - base, 4);
        chk("step_cnt", int'(InstrCount), 4);
        base = acnt;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("pause_busy", int'(Busy), 1);
            chk("pause_ace", int'(bus.A_CE), 0);
        end
        chk("pause_pulses", acnt - base, 0);
        Step = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        Step = 1'b0;
        chk("held_cnt", int'(InstrCount), 6);
        Step_Mode = 1'b0;
        for (int i = 0; i < 60 && !Done; i++) tick();
        chk("step_run_done", int'(Done), 1);
        chk("step_run_cnt", int'(InstrCount), 13);

        // Restart from HALT, then Abort during EXEC of address 5.
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("restart_done", int'(Done), 0);
        chk("restart_cnt", int'(InstrCount), 0);
        chk("restart_addr", int'(bus.Addr), 0);
        chk("restart_busy", int'(Busy), 1);
        for (int i = 0; i < 11; i++) tick();
        chk("pre_abort_addr", int'(bus.Addr), 5);
        chk("pre_abort_rce", int'(bus.Reg_CE), 1);
        Abort = 1'b1;
        #1;
        chk("abort_rce", int'(bus.Reg_CE), 0);
        chk("abort_ace", int'(bus.A_CE), 0);
        tick();
        Abort = 1'b0;
        chk("abort_busy", int'(Busy), 0);
        chk("abort_addr", int'(bus.Addr), 0);
        chk("abort_cnt", int'(InstrCount), 5);
        chk("abort_done", int'(Done), 0);
        Abort = 1'b1;
        Start = 1'b1;
        tick();
        Abort = 1'b0;
        Start = 1'b0;
        chk("abort_start_busy", int'(Busy), 0);
        chk("abort_start_cnt", int'(InstrCount), 5);

        // Asynchronous reset in the middle of EXEC.
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        chk("pre_rst_rce", int'(bus.Reg_CE), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rce", int'(bus.Reg_CE), 0);
        chk("rst_mid_cce", int'(bus.CY_CE), 0);
        chk("rst_mid_ace", int'(bus.A_CE), 0);
        chk("rst_mid_busy", int'(Busy), 0);
        #4;
        rst_n = 1'b1;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("post_rst_addr", int'(bus.Addr), 0);
        chk("post_rst_busy", int'(Busy), 1);
        tick();
        chk("post_rst_ace", int'(bus.A_CE), 1);
        Abort = 1'b1;
        tick();
        Abort = 1'b0;

        // Full 32-entry store: must halt after address 31.
        load_prog_b();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 80 && !Done; i++) tick();
        chk("full_done", int'(Done), 1);
        chk("full_cnt", int'(InstrCount), 32);
        chk("full_addr", int'(bus.Addr), 31);
        chk("full_nowrap", wrapped, 0);
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        chk("halt_abort_done", int'(Done), 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pp_seq.md
PP_SEQ -- requirements
Module: pp_seq

Interface
REQ-001 Parameter ADDR_W, default 5, program address width (32-entry program store).
REQ-002 Parameter HALT_CODE, default 3'b111, ALU code that terminates a program.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  level-sampled; begins a run from address 0.
REQ-006 Abort  input  1  terminates any run; highest priority.
REQ-007 Step_Mode  input  1  1 = pause after every instruction.
REQ-008 Step  input  1  releases one paused instruction.
REQ-009 Addr  output  ADDR_W  program-store address (= PC).
REQ-010 RomRegAddr  input  4  register select from program store.
REQ-011 RomALUCode  input  3  ALU code from program store.
REQ-012 RomReg_CE, RomCY_CE, RomA_CE, RomResetCY  input  1 each  enables from program store.
REQ-013 RegAddr  output  4  one-hot register select to datapath.
REQ-014 ALUCode  output  3  ALU operation to datapath.
REQ-015 Reg_CE, CY_CE, A_CE, ResetCY  output  1 each  datapath enables.
REQ-016 Busy  output  1  high in FETCH, EXEC, WAIT_STEP.
REQ-017 Done  output  1  high in HALT.
REQ-018 InstrCount  output  8  instructions executed in the current run.

Function
REQ-019 Program store is combinational; Addr SHALL be valid the whole FETCH cycle.
REQ-020 States SHALL be IDLE, FETCH, EXEC, WAIT_STEP, HALT.
REQ-021 IDLE/HALT: Start=1 -> FETCH, PC=0, InstrCount=0, Done cleared; else hold.
REQ-022 FETCH: if RomALUCode==HALT_CODE -> HALT, nothing captured; else all Rom* fields SHALL be registered into an instruction register, -> EXEC.
REQ-023 EXEC: instruction-register fields SHALL drive datapath outputs for exactly one cycle; InstrCount +1 (saturate 255).
REQ-024 EXEC exit: PC==31 -> HALT (no wrap); else PC+1 and -> WAIT_STEP if Step_Mode else FETCH.
REQ-025 WAIT_STEP: Step=1 or Step_Mode=0 -> FETCH; else hold.
REQ-026 Throughput SHALL be 2 cycles per instruction when Step_Mode=0.
REQ-027 Outside EXEC: Reg_CE=CY_CE=A_CE=ResetCY=0, RegAddr=4'b0000, ALUCode=3'b000.
REQ-028 Abort=1 SHALL force all four enables to 0 combinationally that cycle; next state IDLE, PC=0; Done=0; InstrCount held.
REQ-029 Abort and Start same cycle: Abort wins.
REQ-030 Start in FETCH/EXEC/WAIT_STEP SHALL be ignored.
REQ-031 Step outside WAIT_STEP SHALL be ignored; a held Step releases one instruction per WAIT_STEP visit.

Reset
REQ-032 rst_n=0 SHALL asynchronously set state IDLE, PC=0, instruction register 0, InstrCount=0, Busy=0, Done=0, all datapath outputs 0.
REQ-033 Reset mid-EXEC SHALL deassert enables immediately, without waiting for clk.

Structure
REQ-034 Package pp_pkg SHALL hold ALU code constants (LD, ADD, SUB, ST, NOT, AND, HALT=3'b111) and the state enum.
REQ-035 Single module; no sub-module, PC and instruction register inline.

Verification
REQ-036 Standard 13-instruction program, Start at cycle 0 -> EXEC of addr k at cycle 2k+2, FETCH of addr 13 at cycle 27 sees HALT_CODE, Done=1 at cycle 28, InstrCount=13.
REQ-037 Step_Mode=1, one Step pulse per pause -> exactly one EXEC per pulse, A_CE high one cycle each; no Step for 10 cycles -> Busy=1, enables 0.
REQ-038 Abort during EXEC of addr 5 -> Reg_CE=0 that cycle, IDLE next cycle, Addr=0, InstrCount=5.
REQ-039 rst_n low during EXEC -> all enables 0 before next clk edge; Start after release runs from addr 0.
REQ-040 Store with 32 non-halt entries -> HALT after addr 31 executed, InstrCount=32, Addr never wraps.
REQ-041 Start in HALT -> Done=0, InstrCount=0, FETCH addr 0 next cycle.
